// File: rtl/decode_pkg.sv
// Shared definitions for the decode queue stage: opcode/funct/rt encodings,
// the ALU operation codes driven to execute, and the decoded control bundle.
// No ports (package).
package decode_pkg;

  localparam logic [5:0] R_TYPE_OP = 6'h00, REGIMM_OP = 6'h01, J_OP    = 6'h02, JAL_OP   = 6'h03;
  localparam logic [5:0] BEQ_OP    = 6'h04, BNE_OP    = 6'h05, BLEZ_OP = 6'h06, BGTZ_OP  = 6'h07;
  localparam logic [5:0] ADDI_OP   = 6'h08, ADDIU_OP  = 6'h09, SLTI_OP = 6'h0A, SLTIU_OP = 6'h0B;
  localparam logic [5:0] ANDI_OP   = 6'h0C, ORI_OP    = 6'h0D, XORI_OP = 6'h0E, LUI_OP   = 6'h0F;
  localparam logic [5:0] LW_OP     = 6'h23, SW_OP     = 6'h2B;

  localparam logic [5:0] SLL_FUNCT = 6'h00, SRL_FUNCT  = 6'h02, SRA_FUNCT = 6'h03, JR_FUNCT  = 6'h08;
  localparam logic [5:0] ADD_FUNCT = 6'h20, ADDU_FUNCT = 6'h21, SUB_FUNCT = 6'h22, SUBU_FUNCT = 6'h23;
  localparam logic [5:0] AND_FUNCT = 6'h24, OR_FUNCT   = 6'h25, XOR_FUNCT = 6'h26, NOR_FUNCT  = 6'h27;
  localparam logic [5:0] SLT_FUNCT = 6'h2A, SLTU_FUNCT = 6'h2B;

  localparam logic [4:0] BLTZ_RT = 5'd0, BGEZ_RT = 5'd1;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_AND  = 5'd1,  ALU_XOR  = 5'd2,  ALU_OR   = 5'd3,
    ALU_NOR  = 5'd4,  ALU_SUB  = 5'd5,  ALU_ANDI = 5'd6,  ALU_XORI = 5'd7,
    ALU_ORI  = 5'd8,  ALU_JR   = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11,
    ALU_BGEZ = 5'd12, ALU_BGTZ = 5'd13, ALU_BLEZ = 5'd14, ALU_BLTZ = 5'd15,
    ALU_SLL  = 5'd16, ALU_SRL  = 5'd17, ALU_SRA  = 5'd18, ALU_SLT  = 5'd19,
    ALU_SLTU = 5'd20, ALU_LUI  = 5'd21
  } alu_code_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    alu_code_t   alu_code;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        reg_dst;
    logic        j;
    logic        jr;
    logic        branch;
    logic        illegal;
  } decode_bundle_t;

endpackage

// File: rtl/decode_queue_stage_ctrl.sv
// Combinational instruction decoder: instr -> decode_bundle_t, plus which
// source registers the instruction reads (used by the load-use check).
// Ports: instr (in, 32), dec (out, bundle), uses_rs / uses_rt (out, 1).
// Build option: DECODE_EXT_EN adds LUI and JAL; without it both decode as illegal.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t dec,
  output logic           uses_rs,
  output logic           uses_rt
);

  logic [5:0] op, funct;
  logic       known, ok, r_type, i_type, is_lw, is_sw, is_lui, is_jal;
  logic       shift, branch, jump, jr, zext;
  alu_code_t  alu;

  always_comb begin
    op     = instr[31:26];
    funct  = instr[5:0];
    known  = 1'b1;
    r_type = 1'b0; i_type = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    is_lui = 1'b0; is_jal = 1'b0; shift = 1'b0; branch = 1'b0;
    jump   = 1'b0; jr = 1'b0; zext = 1'b0;
    alu    = ALU_ADD;
    case (op)
      R_TYPE_OP: begin
        r_type = 1'b1;
        case (funct)
          ADD_FUNCT, ADDU_FUNCT: alu = ALU_ADD;
          SUB_FUNCT, SUBU_FUNCT: alu = ALU_SUB;
          AND_FUNCT:  alu = ALU_AND;
          OR_FUNCT:   alu = ALU_OR;
          XOR_FUNCT:  alu = ALU_XOR;
          NOR_FUNCT:  alu = ALU_NOR;
          SLT_FUNCT:  alu = ALU_SLT;
          SLTU_FUNCT: alu = ALU_SLTU;
          SLL_FUNCT:  begin shift = 1'b1; alu = ALU_SLL; end
          SRL_FUNCT:  begin shift = 1'b1; alu = ALU_SRL; end
          SRA_FUNCT:  begin shift = 1'b1; alu = ALU_SRA; end
          JR_FUNCT:   begin r_type = 1'b0; jr = 1'b1; alu = ALU_JR; end
          default:    begin r_type = 1'b0; known = 1'b0; end
        endcase
      end
      REGIMM_OP: begin
        if (instr[20:16] == BLTZ_RT)      begin branch = 1'b1; alu = ALU_BLTZ; end
        else if (instr[20:16] == BGEZ_RT) begin branch = 1'b1; alu = ALU_BGEZ; end
        else known = 1'b0;
      end
      J_OP:     jump = 1'b1;
      BEQ_OP:   begin branch = 1'b1; alu = ALU_BEQ;  end
      BNE_OP:   begin branch = 1'b1; alu = ALU_BNE;  end
      BLEZ_OP:  begin branch = 1'b1; alu = ALU_BLEZ; end
      BGTZ_OP:  begin branch = 1'b1; alu = ALU_BGTZ; end
      ADDI_OP, ADDIU_OP: i_type = 1'b1;
      SLTI_OP:  begin i_type = 1'b1; alu = ALU_SLT;  end
      SLTIU_OP: begin i_type = 1'b1; alu = ALU_SLTU; end
      ANDI_OP:  begin i_type = 1'b1; zext = 1'b1; alu = ALU_ANDI; end
      ORI_OP:   begin i_type = 1'b1; zext = 1'b1; alu = ALU_ORI;  end
      XORI_OP:  begin i_type = 1'b1; zext = 1'b1; alu = ALU_XORI; end
      LW_OP:    is_lw = 1'b1;
      SW_OP:    is_sw = 1'b1;
`ifdef DECODE_EXT_EN
      LUI_OP:   begin is_lui = 1'b1; alu = ALU_LUI; end
      JAL_OP:   is_jal = 1'b1;
`endif
      default:  known = 1'b0;
    endcase

    // An all-zero word is SLL $0,$0,0: a legal NOP that must not drive any control.
    ok = known && (instr != 32'h0);

    dec            = '0;
    dec.rs         = instr[25:21];
    dec.rt         = instr[20:16];
    dec.rd         = (ok && is_jal) ? 5'd31 : instr[15:11];
    dec.shamt      = instr[10:6];
    if (ok && is_lui)    dec.imm = {instr[15:0], 16'h0};
    else if (ok && zext) dec.imm = {16'h0, instr[15:0]};
    else                 dec.imm = {{16{instr[15]}}, instr[15:0]};
    dec.reg_write  = ok && (is_lw || r_type || i_type || is_lui || is_jal);
    dec.reg_dst    = ok && r_type;
    dec.alu_src_a  = ok && shift;
    dec.alu_src_b  = ok && (i_type || is_lw || is_sw || is_lui);
    dec.mem_to_reg = ok && is_lw;
    dec.mem_read   = ok && is_lw;
    dec.mem_write  = ok && is_sw;
    dec.branch     = ok && branch;
    dec.j          = ok && (jump || is_jal);
    dec.jr         = ok && jr;
    dec.alu_code   = ok ? alu : ALU_ADD;
    dec.illegal    = !known;

    // JAL reads nothing, so it never triggers a load-use bubble.
    uses_rs = (op != J_OP) && (op != JAL_OP);
    uses_rt = r_type || (op == BEQ_OP) || (op == BNE_OP) || is_sw;
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Buffered decode stage between fetch and execute: a DEPTH-entry {pc,instr}
// queue, a decoder on the queue head, and a registered output bundle behind a
// valid/ready handshake. Inserts a one-cycle bubble on load-use hazards and
// counts them (saturating). flush drops everything queued and registered.
// Ports: clk, rst_n (sync, active low), flush; in_valid/in_ready/in_pc/in_instr
// from fetch; out_valid/out_ready plus decoded out_* fields to execute; stall_cnt.
// Build option: DECODE_EXT_EN (LUI/JAL decode, see decode_ctrl).
module decode_queue_stage
  import decode_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [31:0]        in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [31:0]        out_imm,
  output logic [4:0]         out_shamt,
  output logic               out_mem_to_reg,
  output logic               out_reg_write,
  output logic               out_mem_write,
  output logic               out_mem_read,
  output logic [4:0]         out_alu_code,
  output logic               out_alu_src_a,
  output logic               out_alu_src_b,
  output logic               out_reg_dst,
  output logic               out_j,
  output logic               out_jr,
  output logic               out_branch,
  output logic               out_illegal,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  decode_bundle_t  head_dec, out_q;
  logic            head_uses_rs, head_uses_rt;
  logic            non_empty, out_free, hazard, load, push;

  decode_ctrl u_ctrl (
    .instr   (instr_mem[rd_ptr]),
    .dec     (head_dec),
    .uses_rs (head_uses_rs),
    .uses_rt (head_uses_rt)
  );

  // Full blocks a push even if the head pops in the same cycle.
  assign in_ready  = rst_n && (count != FULL);
  assign push      = in_valid && in_ready && !flush;
  assign non_empty = (count != '0);
  assign out_free  = !out_valid || out_ready;
  assign hazard    = non_empty && out_valid && out_q.mem_read && (out_q.rt != 5'd0) &&
                     ((head_uses_rs && head_dec.rs == out_q.rt) ||
                      (head_uses_rt && head_dec.rt == out_q.rt));
  assign load      = non_empty && out_free && !hazard;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_q     <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_q     <= head_dec;
        out_pc    <= pc_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (out_free) begin
        out_valid <= 1'b0;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
      // A hazard seen while execute drains the load becomes exactly one bubble.
      if (hazard && out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_rs         = out_q.rs;
  assign out_rt         = out_q.rt;
  assign out_rd         = out_q.rd;
  assign out_imm        = out_q.imm;
  assign out_shamt      = out_q.shamt;
  assign out_mem_to_reg = out_q.mem_to_reg;
  assign out_reg_write  = out_q.reg_write;
  assign out_mem_write  = out_q.mem_write;
  assign out_mem_read   = out_q.mem_read;
  assign out_alu_code   = out_q.alu_code;
  assign out_alu_src_a  = out_q.alu_src_a;
  assign out_alu_src_b  = out_q.alu_src_b;
  assign out_reg_dst    = out_q.reg_dst;
  assign out_j          = out_q.j;
  assign out_jr         = out_q.jr;
  assign out_branch     = out_q.branch;
  assign out_illegal    = out_q.illegal;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage. Build option: DECODE_EXT_EN selects LUI expectations.
module tb_decode_queue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_imm;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt, out_alu_code;
  logic        out_mem_to_reg, out_reg_write, out_mem_write, out_mem_read;
  logic        out_alu_src_a, out_alu_src_b, out_reg_dst, out_j, out_jr, out_branch, out_illegal;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  decode_queue_stage #(.DEPTH(4), .PC_W(32), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm), .out_shamt(out_shamt),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
    .out_alu_code(out_alu_code), .out_alu_src_a(out_alu_src_a), .out_alu_src_b(out_alu_src_b),
    .out_reg_dst(out_reg_dst), .out_j(out_j), .out_jr(out_jr), .out_branch(out_branch),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    tick; tick;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", out_valid); n_fail++; end
    n_checks++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b want 0", in_ready); n_fail++; end
    n_checks++; if (stall_cnt !== 16'd0) begin $display("FAIL reset_stall got %0d want 0", stall_cnt); n_fail++; end
    n_checks++; if (out_pc !== 32'd0 || out_imm !== 32'd0) begin $display("FAIL reset_fields got pc=%h imm=%h want 0", out_pc, out_imm); n_fail++; end
    rst_n = 1'b1;
    tick;
    n_checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_release_ready got %b want 1", in_ready); n_fail++; end
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_release_valid got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h00851020;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL basic_cycle1 got %b want 0", out_valid); n_fail++; end
    in_pc = 32'h104; in_instr = 32'h34A50010;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin $display("FAIL basic_add_valid got v=%b pc=%h want 1/100", out_valid, out_pc); n_fail++; end
    n_checks++; if (out_alu_code !== 5'b00000 || out_rs !== 5'd4 || out_rt !== 5'd5 || out_rd !== 5'd2) begin
      $display("FAIL basic_add_fields got alu=%b rs=%0d rt=%0d rd=%0d want 00000/4/5/2", out_alu_code, out_rs, out_rt, out_rd); n_fail++; end
    n_checks++; if ({out_reg_write, out_reg_dst, out_alu_src_b, out_illegal} !== 4'b1100) begin
      $display("FAIL basic_add_ctrl got %b want 1100", {out_reg_write, out_reg_dst, out_alu_src_b, out_illegal}); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_alu_code !== 5'b01000) begin
      $display("FAIL basic_ori got v=%b pc=%h alu=%b want 1/104/01000", out_valid, out_pc, out_alu_code); n_fail++; end
    n_checks++; if (out_imm !== 32'h00000010 || out_alu_src_b !== 1'b1 || out_reg_dst !== 1'b0) begin
      $display("FAIL basic_ori_imm got imm=%h srcb=%b dst=%b want 00000010/1/0", out_imm, out_alu_src_b, out_reg_dst); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL basic_drain got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_load_use;
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'h8C240000;
    tick;
    in_pc = 32'h204; in_instr = 32'h00851020;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_mem_read !== 1'b1 || out_mem_to_reg !== 1'b1 || out_rt !== 5'd4) begin
      $display("FAIL lu_lw got v=%b mr=%b m2r=%b rt=%0d want 1/1/1/4", out_valid, out_mem_read, out_mem_to_reg, out_rt); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL lu_bubble got %b want 0", out_valid); n_fail++; end
    n_checks++; if (stall_cnt !== 16'd1) begin $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_mem_read !== 1'b0) begin
      $display("FAIL lu_add got v=%b pc=%h mr=%b want 1/204/0", out_valid, out_pc, out_mem_read); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd1) begin
      $display("FAIL lu_after got v=%b stall=%0d want 0/1", out_valid, stall_cnt); n_fail++; end
  endtask

  task automatic test_full;
    logic [31:0] addi_base;
    addi_base = 32'h20010000;
    out_ready = 1'b0;
    // The output register absorbs the first entry, so five are accepted in total.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4*k); in_instr = addi_base | 32'(k);
      n_checks++; if (in_ready !== 1'b1) begin $display("FAIL full_accept%0d got %b want 1", k, in_ready); n_fail++; end
      tick;
    end
    n_checks++; if (in_ready !== 1'b0) begin $display("FAIL full_in_ready got %b want 0", in_ready); n_fail++; end
    in_pc = 32'h3FC; in_instr = addi_base | 32'h7F;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin $display("FAIL full_hold got v=%b pc=%h want 1/300", out_valid, out_pc); n_fail++; end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin $display("FAIL full_pop_ready got %b want 0", in_ready); n_fail++; end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 + 32'(4*k) || out_imm !== 32'(k)) begin
        $display("FAIL full_order%0d got v=%b pc=%h imm=%h want 1/%h/%h", k, out_valid, out_pc, out_imm, 32'h300 + 32'(4*k), k); n_fail++; end
      tick;
    end
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL full_no_extra got v=%b pc=%h want 0", out_valid, out_pc); n_fail++; end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4*k); in_instr = 32'h00851020;
      tick;
    end
    flush = 1'b1; in_pc = 32'h4F0;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL flush_state got v=%b rdy=%b want 0/1", out_valid, in_ready); n_fail++; end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_empty%0d got v=%b pc=%h want 0", k, out_valid, out_pc); n_fail++; end
    end
    n_checks++; if (stall_cnt !== 16'd1) begin $display("FAIL flush_stall_kept got %0d want 1", stall_cnt); n_fail++; end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'hFC000000;
    tick;
    in_pc = 32'h504; in_instr = 32'h3C011234;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_alu_src_b !== 1'b0) begin
      $display("FAIL ill_op3f got v=%b ill=%b rw=%b srcb=%b want 1/1/0/0", out_valid, out_illegal, out_reg_write, out_alu_src_b); n_fail++; end
    in_pc = 32'h508; in_instr = 32'h00000000;
    tick;
`ifdef DECODE_EXT_EN
    n_checks++; if (out_illegal !== 1'b0 || out_imm !== 32'h12340000 || out_alu_code !== 5'b10101 || out_reg_write !== 1'b1 || out_alu_src_b !== 1'b1) begin
      $display("FAIL lui_ext got ill=%b imm=%h alu=%b rw=%b srcb=%b want 0/12340000/10101/1/1", out_illegal, out_imm, out_alu_code, out_reg_write, out_alu_src_b); n_fail++; end
`else
    n_checks++; if (out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_alu_code !== 5'b00000) begin
      $display("FAIL lui_base got ill=%b rw=%b alu=%b want 1/0/00000", out_illegal, out_reg_write, out_alu_code); n_fail++; end
`endif
    in_pc = 32'h50C; in_instr = 32'h04600008;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_reg_write !== 1'b0 || out_reg_dst !== 1'b0 || out_alu_src_a !== 1'b0) begin
      $display("FAIL nop got v=%b ill=%b rw=%b dst=%b srca=%b want 1/0/0/0/0", out_valid, out_illegal, out_reg_write, out_reg_dst, out_alu_src_a); n_fail++; end
    tick;
    n_checks++; if (out_alu_code !== 5'b01111 || out_branch !== 1'b1 || out_imm !== 32'h8 || out_rs !== 5'd3 || out_pc !== 32'h50C) begin
      $display("FAIL bltz got alu=%b br=%b imm=%h rs=%0d pc=%h want 01111/1/8/3/50c", out_alu_code, out_branch, out_imm, out_rs, out_pc); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL ill_drain got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_pc = 32'h600 + 32'(4*k); in_instr = 32'h34A5FFFF;
      tick;
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin $display("FAIL rmid_ready_low got %b want 0", in_ready); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_imm !== 32'd0 || out_rs !== 5'd0 || out_alu_code !== 5'd0 || out_reg_write !== 1'b0) begin
      $display("FAIL rmid_fields got v=%b pc=%h imm=%h rs=%0d alu=%b rw=%b want all 0", out_valid, out_pc, out_imm, out_rs, out_alu_code, out_reg_write); n_fail++; end
    n_checks++; if (stall_cnt !== 16'd0 || in_ready !== 1'b0) begin $display("FAIL rmid_stall got stall=%0d rdy=%b want 0/0", stall_cnt, in_ready); n_fail++; end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL rmid_resume got v=%b rdy=%b want 0/1", out_valid, in_ready); n_fail++; end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL rmid_empty got %b want 0", out_valid); n_fail++; end
    in_valid = 1'b1; in_pc = 32'h700; in_instr = 32'h00851020;
    tick;
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h700) begin $display("FAIL rmid_after got v=%b pc=%h want 1/700", out_valid, out_pc); n_fail++; end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_load_use;
    test_full;
    test_flush;
    test_illegal;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
